modulo_registro_ataque: RTL and testbench

Attack-phase shot register for the naval-battle board. It takes the debounced confirm button and the current attack coordinate (column 0–4, line 0–6) and checks the shot against the 35-bit position matrix. It accumulates the 35-bit attack and hit matrices for the LED-matrix line multiplexers, drives the two-bit RGB hit/miss feedback, and flags game over once every ship cell has been hit. It sits between the coordinate counter / debouncer and the attack-matrix display muxes.

---
 rtl/modulo_registro_ataque.sv | 157 +++++++++++++++
 tb/tb_modulo_registro_ataque.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_registro_ataque.sv
// Attack-phase shot register: edge-detects confirm, checks the shot against the position matrix,
// and accumulates attack/hit matrices, counters, RGB feedback and game over.
module modulo_registro_ataque #(
  parameter int FEEDBACK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        game_en,
  input  logic        confirm,
  input  logic [2:0]  coord_col,
  input  logic [2:0]  coord_lin,
  input  logic [34:0] m_po,
  output logic [34:0] m_at,
  output logic [34:0] m_hit,
  output logic [1:0]  rgb_output,
  output logic [5:0]  shots,
  output logic [5:0]  hits,
  output logic        game_over,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for a valid shot request
  // CHECK | evaluating the latched cell against m_po
  // SHOW  | holding RGB feedback until the timer expires
  // OVER  | all ship cells hit, requests ignored until game_en drops
  typedef enum logic [1:0] {IDLE, CHECK, SHOW, OVER} state_t;

  localparam logic [7:0]  TIMER_LOAD = 8'(FEEDBACK_CYCLES - 1);
  localparam logic [34:0] CELL0      = 35'h4_0000_0000;

  state_t      state_q, state_d;
  logic        confirm_q, confirm_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  timer_q, timer_d;
  logic [34:0] m_at_q, m_at_d, m_hit_q, m_hit_d;
  logic [5:0]  shots_q, shots_d, hits_q, hits_d;
  logic [1:0]  rgb_q, rgb_d;
  logic        over_q, over_d;

  logic        req, coord_ok;
  logic [5:0]  po_cnt;
  logic [34:0] cell_mask;

  assign req       = confirm & ~confirm_q;
  assign coord_ok  = (coord_col <= 3'd4) && (coord_lin <= 3'd6);
  assign cell_mask = CELL0 >> idx_q;

  always_comb begin
    po_cnt = '0;
    for (int i = 0; i < 35; i++) po_cnt = po_cnt + {5'd0, m_po[i]};
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!game_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (req && coord_ok) state_d = CHECK;
        CHECK:   state_d = SHOW;
        SHOW:    if (timer_q == 8'd0) state_d = over_q ? OVER : IDLE;
        OVER:    state_d = OVER;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == CHECK) || (state_q == SHOW);
  end

  always_comb begin
    confirm_d = confirm;
    idx_d     = idx_q;
    timer_d   = timer_q;
    m_at_d    = m_at_q;
    m_hit_d   = m_hit_q;
    shots_d   = shots_q;
    hits_d    = hits_q;
    rgb_d     = rgb_q;
    over_d    = over_q;
    if (!game_en) begin
      timer_d = '0;
      m_at_d  = '0;
      m_hit_d = '0;
      shots_d = '0;
      hits_d  = '0;
      rgb_d   = 2'b00;
      over_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req && coord_ok) idx_d = ({3'b000, coord_lin} * 6'd5) + {3'b000, coord_col};
        CHECK: begin
          timer_d = TIMER_LOAD;
          if ((m_at_q & cell_mask) != '0) begin
            rgb_d = 2'b11;
          end else begin
            m_at_d  = m_at_q | cell_mask;
            shots_d = shots_q + 6'd1;
            if ((m_po & cell_mask) != '0) begin
              m_hit_d = m_hit_q | cell_mask;
              hits_d  = hits_q + 6'd1;
              rgb_d   = 2'b10;
              // m_po is sampled here, so the completion test uses this edge's popcount
              if ((po_cnt != 6'd0) && (hits_q + 6'd1 == po_cnt)) over_d = 1'b1;
            end else begin
              rgb_d = 2'b01;
            end
          end
        end
        SHOW: begin
          if (timer_q == 8'd0) rgb_d = 2'b00;
          else                 timer_d = timer_q - 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      confirm_q <= 1'b0;
      idx_q     <= '0;
      timer_q   <= '0;
      m_at_q    <= '0;
      m_hit_q   <= '0;
      shots_q   <= '0;
      hits_q    <= '0;
      rgb_q     <= 2'b00;
      over_q    <= 1'b0;
    end else begin
      confirm_q <= confirm_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      m_at_q    <= m_at_d;
      m_hit_q   <= m_hit_d;
      shots_q   <= shots_d;
      hits_q    <= hits_d;
      rgb_q     <= rgb_d;
      over_q    <= over_d;
    end
  end

  assign m_at       = m_at_q;
  assign m_hit      = m_hit_q;
  assign shots      = shots_q;
  assign hits       = hits_q;
  assign rgb_output = rgb_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_modulo_registro_ataque.sv
// Self-checking bench for modulo_registro_ataque against a cell-level model of the board.
module tb_modulo_registro_ataque;
  localparam int F = 4;

  logic        clk = 1'b0;
  logic        clr, game_en, confirm;
  logic [2:0]  coord_col, coord_lin;
  logic [34:0] m_po;
  logic [34:0] m_at, m_hit;
  logic [1:0]  rgb_output;
  logic [5:0]  shots, hits;
  logic        game_over, busy;

  int checks = 0, failures = 0;

  bit shot_m[35];
  bit ship_m[35];
  int shots_m, hits_m, ships_m;
  bit over_m;

  modulo_registro_ataque #(.FEEDBACK_CYCLES(F)) dut (
    .clk(clk), .clr(clr), .game_en(game_en), .confirm(confirm),
    .coord_col(coord_col), .coord_lin(coord_lin), .m_po(m_po),
    .m_at(m_at), .m_hit(m_hit), .rgb_output(rgb_output), .shots(shots),
    .hits(hits), .game_over(game_over), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cell n = 5*lin+col lives at matrix bit 34-n.
  function automatic logic [34:0] exp_at();
    logic [34:0] r = '0;
    for (int n = 0; n < 35; n++) if (shot_m[n]) r[34-n] = 1'b1;
    return r;
  endfunction

  function automatic logic [34:0] exp_hit();
    logic [34:0] r = '0;
    for (int n = 0; n < 35; n++) if (shot_m[n] && ship_m[n]) r[34-n] = 1'b1;
    return r;
  endfunction

  task automatic model_clear();
    for (int n = 0; n < 35; n++) shot_m[n] = 1'b0;
    shots_m = 0; hits_m = 0; over_m = 1'b0;
  endtask

  task automatic load_po(input logic [34:0] v);
    m_po = v; ships_m = 0;
    for (int n = 0; n < 35; n++) begin
      ship_m[n] = v[34-n];
      if (ship_m[n]) ships_m++;
    end
  endtask

  task automatic model_apply(input int n, output logic [1:0] rgb_e);
    if (shot_m[n]) rgb_e = 2'b11;
    else begin
      shot_m[n] = 1'b1; shots_m++;
      if (ship_m[n]) begin hits_m++; rgb_e = 2'b10; end
      else rgb_e = 2'b01;
    end
    over_m = (ships_m > 0) && (hits_m == ships_m);
  endtask

  function automatic logic [34:0] sparse_po(input int k);
    logic [34:0] v = '0;
    for (int i = 0; i < k; i++) v[$urandom_range(0, 34)] = 1'b1;
    return v;
  endfunction

  task automatic mode_clear();
    game_en = 1'b0; confirm = 1'b0;
    tick();
    checks++; if (m_at !== '0 || m_hit !== '0) begin failures++; $display("FAIL mode_clear_matrix: m_at=%h m_hit=%h required 0", m_at, m_hit); end
    checks++; if (shots !== 0 || hits !== 0 || rgb_output !== 0 || game_over !== 0 || busy !== 0) begin
      failures++; $display("FAIL mode_clear_status: shots=%0d hits=%0d rgb=%b go=%b busy=%b required all 0", shots, hits, rgb_output, game_over, busy);
    end
    game_en = 1'b1;
    model_clear();
  endtask

  // One press at (col,lin); optionally replaces m_po after the request edge.
  task automatic do_shot(input int col, input int lin, input bit late, input logic [34:0] po_late);
    bit accept;
    int n;
    logic [1:0] rgb_e;
    accept = (col <= 4) && (lin <= 6) && !over_m;
    n = 5 * lin + col;
    coord_col = col[2:0]; coord_lin = lin[2:0]; confirm = 1'b1;
    tick();
    confirm = 1'b0;
    if (!accept) begin
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignored_busy (%0d,%0d): busy=%b required 0", col, lin, busy); end
      tick();
      checks++; if (m_at !== exp_at() || shots !== 6'(shots_m) || rgb_output !== 2'b00) begin
        failures++; $display("FAIL ignored_state (%0d,%0d): m_at=%h shots=%0d rgb=%b required %h %0d 00", col, lin, m_at, shots, rgb_output, exp_at(), shots_m);
      end
      return;
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL req_busy (%0d,%0d): busy=%b required 1", col, lin, busy); end
    if (late) load_po(po_late);
    model_apply(n, rgb_e);
    tick();
    checks++; if (m_at !== exp_at()) begin failures++; $display("FAIL m_at (%0d,%0d): got %h required %h", col, lin, m_at, exp_at()); end
    checks++; if (m_hit !== exp_hit()) begin failures++; $display("FAIL m_hit (%0d,%0d): got %h required %h", col, lin, m_hit, exp_hit()); end
    checks++; if (shots !== 6'(shots_m) || hits !== 6'(hits_m)) begin
      failures++; $display("FAIL counts (%0d,%0d): shots=%0d hits=%0d required %0d %0d", col, lin, shots, hits, shots_m, hits_m);
    end
    checks++; if (rgb_output !== rgb_e) begin failures++; $display("FAIL rgb (%0d,%0d): got %b required %b", col, lin, rgb_output, rgb_e); end
    checks++; if (game_over !== over_m) begin failures++; $display("FAIL game_over (%0d,%0d): got %b required %b", col, lin, game_over, over_m); end
    for (int j = 1; j < F; j++) begin
      tick();
      checks++; if (rgb_output !== rgb_e || busy !== 1'b1) begin
        failures++; $display("FAIL rgb_hold (%0d,%0d) cycle %0d: rgb=%b busy=%b required %b 1", col, lin, j, rgb_output, busy, rgb_e);
      end
    end
    tick();
    checks++; if (rgb_output !== 2'b00 || busy !== 1'b0) begin
      failures++; $display("FAIL show_end (%0d,%0d): rgb=%b busy=%b required 00 0", col, lin, rgb_output, busy);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; game_en = 1'b0; confirm = 1'b0; coord_col = 0; coord_lin = 0; m_po = '0;
    #3;
    checks++; if (m_at !== '0 || m_hit !== '0 || shots !== 0 || hits !== 0 || rgb_output !== 0 || game_over !== 0 || busy !== 0) begin
      failures++; $display("FAIL reset_async: m_at=%h shots=%0d rgb=%b busy=%b required all 0", m_at, shots, rgb_output, busy);
    end
    tick(); tick();
    clr = 1'b1; game_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (m_at !== '0 || m_hit !== '0 || shots !== 0 || hits !== 0 || rgb_output !== 0 || game_over !== 0 || busy !== 0) begin
      failures++; $display("FAIL reset_hold: m_at=%h shots=%0d rgb=%b busy=%b required all 0", m_at, shots, rgb_output, busy);
    end
    model_clear();
  endtask

  task automatic test_miss_hit();
    mode_clear();
    load_po(35'h4_0000_0000);
    do_shot(1, 0, 1'b0, '0);
    checks++; if (m_at !== 35'h2_0000_0000) begin failures++; $display("FAIL miss_bit33: m_at=%h required 200000000", m_at); end
    do_shot(0, 0, 1'b0, '0);
    do_shot(2, 0, 1'b0, '0);
    checks++; if (game_over !== 1'b1) begin failures++; $display("FAIL over_sticky: game_over=%b required 1", game_over); end
  endtask

  task automatic test_repeat_invalid();
    mode_clear();
    load_po('0);
    do_shot(3, 2, 1'b0, '0);
    do_shot(3, 2, 1'b0, '0);
    checks++; if (shots !== 6'd1) begin failures++; $display("FAIL repeat_shots: shots=%0d required 1", shots); end
    do_shot(5, 0, 1'b0, '0);
    do_shot(2, 7, 1'b0, '0);
  endtask

  task automatic test_held_button();
    int n1, n2, n3, w;
    logic [1:0] rgb_e;
    mode_clear();
    load_po(sparse_po(4));
    n1 = $urandom_range(0, 34); n2 = (n1 + 1) % 35; n3 = (n1 + 2) % 35;
    coord_col = 3'(n1 % 5); coord_lin = 3'(n1 / 5); confirm = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    model_apply(n1, rgb_e);
    checks++; if (shots !== 6'(shots_m) || m_at !== exp_at() || busy !== 1'b0) begin
      failures++; $display("FAIL held_button: shots=%0d m_at=%h busy=%b required %0d %h 0", shots, m_at, busy, shots_m, exp_at());
    end
    confirm = 1'b0; tick();
    coord_col = 3'(n2 % 5); coord_lin = 3'(n2 / 5); confirm = 1'b1;
    tick(); confirm = 1'b0; tick(); tick();
    coord_col = 3'(n3 % 5); coord_lin = 3'(n3 / 5); confirm = 1'b1;
    tick(); confirm = 1'b0;
    model_apply(n2, rgb_e);
    w = 0;
    while (busy === 1'b1 && w < 20) begin tick(); w++; end
    checks++; if (w >= 20) begin failures++; $display("FAIL show_timeout: busy=%b after %0d cycles required 0", busy, w); end
    checks++; if (shots !== 6'(shots_m) || m_at !== exp_at()) begin
      failures++; $display("FAIL confirm_in_show: shots=%0d m_at=%h required %0d %h", shots, m_at, shots_m, exp_at());
    end
  endtask

  task automatic test_po_sampling();
    int n;
    logic [34:0] v;
    mode_clear();
    load_po('0);
    n = $urandom_range(0, 34);
    v = '0; v[34-n] = 1'b1;
    do_shot(n % 5, n / 5, 1'b1, v);
    checks++; if (hits !== 6'd1 || game_over !== 1'b1) begin failures++; $display("FAIL po_late: hits=%0d go=%b required 1 1", hits, game_over); end
  endtask

  task automatic test_full_game();
    logic [34:0] v;
    mode_clear();
    v = '0; v[0] = 1'b1;
    while ($countones(v) < 3) v[$urandom_range(1, 34)] = 1'b1;
    load_po(v);
    for (int n = 0; n < 35; n++) do_shot(n % 5, n / 5, 1'b0, '0);
    checks++; if (shots !== 6'd35 || hits !== 6'd3 || game_over !== 1'b1) begin
      failures++; $display("FAIL full_game: shots=%0d hits=%0d go=%b required 35 3 1", shots, hits, game_over);
    end
    do_shot(1, 1, 1'b0, '0);
  endtask

  task automatic test_mode_exit();
    int n;
    mode_clear();
    load_po(sparse_po(5));
    n = $urandom_range(0, 34);
    coord_col = 3'(n % 5); coord_lin = 3'(n / 5); confirm = 1'b1;
    tick(); confirm = 1'b0; tick(); tick();
    game_en = 1'b0;
    tick();
    checks++; if (m_at !== '0 || m_hit !== '0 || shots !== 0 || hits !== 0 || rgb_output !== 0 || game_over !== 0 || busy !== 0) begin
      failures++; $display("FAIL mode_exit: m_at=%h shots=%0d rgb=%b busy=%b required all 0", m_at, shots, rgb_output, busy);
    end
    confirm = 1'b1; tick();
    game_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (busy !== 1'b0 || shots !== 0) begin failures++; $display("FAIL held_across_enable: busy=%b shots=%0d required 0 0", busy, shots); end
    confirm = 1'b0; tick();
    model_clear();
    do_shot(n % 5, n / 5, 1'b0, '0);
  endtask

  task automatic test_reset_mid_show();
    int n;
    mode_clear();
    load_po(sparse_po(3));
    n = $urandom_range(0, 34);
    coord_col = 3'(n % 5); coord_lin = 3'(n / 5); confirm = 1'b1;
    tick(); confirm = 1'b0; tick(); tick();
    #2 clr = 1'b0;
    #1;
    checks++; if (m_at !== '0 || m_hit !== '0 || shots !== 0 || hits !== 0 || rgb_output !== 0 || busy !== 0) begin
      failures++; $display("FAIL reset_mid_show: m_at=%h shots=%0d rgb=%b busy=%b required all 0", m_at, shots, rgb_output, busy);
    end
    tick(); clr = 1'b1; tick();
    model_clear();
    do_shot(n % 5, n / 5, 1'b0, '0);
  endtask

  task automatic test_random();
    mode_clear();
    load_po(sparse_po(4));
    for (int i = 0; i < 60; i++) do_shot($urandom_range(0, 5), $urandom_range(0, 7), 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_repeat_invalid();
    test_held_button();
    test_po_sampling();
    test_full_game();
    test_mode_exit();
    test_reset_mid_show();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
